fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus for the fetch stage
// Purpose: bundles the single-outstanding imem request and response handshakes.
// Signals:
//   imem_req_valid / imem_req_addr / imem_req_ready : read request (master -> slave)
//   imem_rsp_valid / imem_rsp_data / imem_rsp_ready : read response (slave -> master)
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_ready;

   modport master (
      output imem_req_valid, imem_req_addr, imem_rsp_ready,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, imem_rsp_ready,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and redirect handling
// Purpose: issues one instruction read at a time, loads the IF/ID register, honours
//          load-use stalls and branch/jump redirects (in-flight responses are dropped).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   hazard_stall        : hold IF/ID contents
//   redirect_valid/_pc  : flush and refetch from redirect_pc
//   imem (master)       : instruction memory request/response bus
//   id_valid/id_pc/id_instr and decoded fields id_opcode/id_rs1/id_rs2/id_funct3
// Build option: define FETCH_SKID_EN to add a one-entry skid buffer so responses
//               are still accepted during hazard_stall.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hazard_stall,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   fetch_stage_if.master imem,
   output logic         id_valid,
   output logic [31:0]  id_pc,
   output logic [31:0]  id_instr,
   output logic [4:0]   id_opcode,
   output logic [4:0]   id_rs1,
   output logic [4:0]   id_rs2,
   output logic [2:0]   id_funct3
);
   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;          // address of the next (or currently offered) request
   logic [31:0] req_pc_q, req_pc_d;  // address of the outstanding request
   logic [31:0] tgt_q, tgt_d;        // redirect target captured while a request is held
   logic        hold_q, hold_d;      // request offered but not yet accepted
   logic        flush_q, flush_d;    // held request must be dropped once accepted
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic        blocked;
   logic        req_hs, rsp_hs, accept;

`ifdef FETCH_SKID_EN
   logic        skid_full_q, skid_full_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   assign blocked = skid_full_q;
`else
   assign blocked = hazard_stall;
`endif

   // A held request stays up regardless of stall/redirect; a fresh one is not
   // started in a redirect cycle so the next request goes straight to the target.
   assign imem.imem_req_valid = (state_q == S_REQ) && !rst &&
                                (hold_q || (!blocked && !redirect_valid));
   assign imem.imem_req_addr  = pc_q;

   always_comb begin
      imem.imem_rsp_ready = 1'b0;
      case (state_q)
`ifdef FETCH_SKID_EN
         S_WAIT:  imem.imem_rsp_ready = !skid_full_q;
`else
         S_WAIT:  imem.imem_rsp_ready = !hazard_stall;
`endif
         S_DROP:  imem.imem_rsp_ready = 1'b1;
         default: imem.imem_rsp_ready = 1'b0;
      endcase
   end

   assign req_hs = imem.imem_req_valid && imem.imem_req_ready;
   assign rsp_hs = imem.imem_rsp_valid && imem.imem_rsp_ready;
   // A response coincident with a redirect is discarded.
   assign accept = rsp_hs && (state_q == S_WAIT) && !redirect_valid;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      tgt_d    = tgt_q;
      hold_d   = hold_q;
      flush_d  = flush_q;
      case (state_q)
         S_REQ: begin
            if (req_hs) begin
               req_pc_d = pc_q;
               hold_d   = 1'b0;
               flush_d  = 1'b0;
               if (redirect_valid || flush_q) begin
                  state_d = S_DROP;
                  pc_d    = redirect_valid ? redirect_pc : tgt_q;
               end else begin
                  state_d = S_WAIT;
                  pc_d    = pc_q + 32'd4;
               end
            end else if (imem.imem_req_valid) begin
               hold_d = 1'b1;
               if (redirect_valid) begin
                  flush_d = 1'b1;
                  tgt_d   = redirect_pc;
               end
            end else if (redirect_valid) begin
               pc_d = redirect_pc;
            end
         end
         S_WAIT: begin
            if (rsp_hs) begin
               state_d = S_REQ;
               if (redirect_valid) pc_d = redirect_pc;
            end else if (redirect_valid) begin
               state_d = S_DROP;
               pc_d    = redirect_pc;
            end
         end
         S_DROP: begin
            if (redirect_valid) pc_d = redirect_pc;
            if (imem.imem_rsp_valid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   always_comb begin
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
`ifdef FETCH_SKID_EN
      skid_full_d  = skid_full_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
`endif
      if (redirect_valid) begin
         id_valid_d = 1'b0;
`ifdef FETCH_SKID_EN
         skid_full_d = 1'b0;
`endif
      end else if (hazard_stall) begin
`ifdef FETCH_SKID_EN
         if (accept) begin
            skid_full_d  = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem.imem_rsp_data;
         end
`endif
`ifdef FETCH_SKID_EN
      end else if (skid_full_q) begin
         id_valid_d  = 1'b1;
         id_pc_d     = skid_pc_q;
         id_instr_d  = skid_instr_q;
         skid_full_d = 1'b0;
`endif
      end else if (accept) begin
         id_valid_d = 1'b1;
         id_pc_d    = req_pc_q;
         id_instr_d = imem.imem_rsp_data;
      end else begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= 32'd0;
         tgt_q      <= 32'd0;
         hold_q     <= 1'b0;
         flush_q    <= 1'b0;
         id_valid_q <= 1'b0;
         id_pc_q    <= 32'd0;
         id_instr_q <= NOP;
`ifdef FETCH_SKID_EN
         skid_full_q  <= 1'b0;
         skid_pc_q    <= 32'd0;
         skid_instr_q <= NOP;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         tgt_q      <= tgt_d;
         hold_q     <= hold_d;
         flush_q    <= flush_d;
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
`ifdef FETCH_SKID_EN
         skid_full_q  <= skid_full_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
`endif
      end
   end

   assign id_valid  = id_valid_q;
   assign id_pc     = id_pc_q;
   assign id_instr  = id_instr_q;
   assign id_opcode = id_instr_q[6:2];
   assign id_rs1    = id_instr_q[19:15];
   assign id_rs2    = id_instr_q[24:20];
   assign id_funct3 = id_instr_q[14:12];
endmodule
